hash_writer: RTL and testbench

HASH_WRITER -- requirements
Module: hash_writer

---
 rtl/sha256_pkg.sv | 14 +
 rtl/hash_word_select.sv | 34 +++
 rtl/hash_writer.sv | 98 +++++++++
 tb/tb_hash_writer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 datapath blocks: word geometry and the
// hash writer state encoding.
package sha256_pkg;

    localparam int HASH_LENGTH = 8;
    localparam int WORD_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } writer_state_t;

endpackage

// File: rtl/hash_word_select.sv
// Picks word word_index out of a packed digest and bit-reverses it, undoing
// the hash assembler's read mapping (word_data[31-b] = vector[k*32+b]).
module hash_word_select
    import sha256_pkg::*;
#(
    parameter int HASH_LENGTH = sha256_pkg::HASH_LENGTH,
    parameter int INDEX_WIDTH = $clog2(HASH_LENGTH)
) (
    input  logic [HASH_LENGTH*WORD_WIDTH-1:0] hash_vector,
    input  logic [INDEX_WIDTH-1:0]            word_index,
    output logic [WORD_WIDTH-1:0]             word_data
);

    logic [WORD_WIDTH-1:0] selected;

    // Constant part-selects keep the mux free of out-of-range indexing when
    // HASH_LENGTH is not a power of two.
    always_comb begin
        selected = '0;
        for (int k = 0; k < HASH_LENGTH; k++) begin
            if (word_index == INDEX_WIDTH'(k)) begin
                selected = hash_vector[k*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    always_comb begin
        word_data = '0;
        for (int b = 0; b < WORD_WIDTH; b++) begin
            word_data[WORD_WIDTH-1-b] = selected[b];
        end
    end

endmodule

// File: rtl/hash_writer.sv
// Writes a latched HASH_LENGTH-word digest to memory one word per accepted
// cycle, starting at BASE_ADDR, then pulses done.
module hash_writer
    import sha256_pkg::*;
#(
    parameter int                    HASH_LENGTH = sha256_pkg::HASH_LENGTH,
    parameter int                    ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [HASH_LENGTH*WORD_WIDTH-1:0] hash_vector,
    input  logic                              mem_ready,
    output logic [ADDR_WIDTH-1:0]             mem_address,
    output logic [WORD_WIDTH-1:0]             mem_data,
    output logic                              mem_write_en,
    output logic                              busy,
    output logic                              done
);

    localparam int                     INDEX_WIDTH = $clog2(HASH_LENGTH);
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX  = INDEX_WIDTH'(HASH_LENGTH - 1);

    writer_state_t                     state;
    writer_state_t                     state_next;
    logic [INDEX_WIDTH-1:0]            word_index;
    logic [INDEX_WIDTH-1:0]            index_next;
    logic [HASH_LENGTH*WORD_WIDTH-1:0] latched_vector;
    logic [HASH_LENGTH*WORD_WIDTH-1:0] latched_next;
    logic [WORD_WIDTH-1:0]             current_word;

    hash_word_select #(
        .HASH_LENGTH(HASH_LENGTH),
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_word_select (
        .hash_vector(latched_vector),
        .word_index (word_index),
        .word_data  (current_word)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            word_index     <= '0;
            latched_vector <= '0;
        end else begin
            state          <= state_next;
            word_index     <= index_next;
            latched_vector <= latched_next;
        end
    end

    // Outputs decode straight from registered state, so a stall (mem_ready=0)
    // holds address and data simply by leaving word_index untouched.
    always_comb begin
        state_next   = state;
        index_next   = word_index;
        latched_next = latched_vector;
        mem_write_en = 1'b0;
        mem_address  = '0;
        mem_data     = '0;
        busy         = 1'b0;
        done         = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    latched_next = hash_vector;
                    index_next   = '0;
                    state_next   = WRITE;
                end
            end
            WRITE: begin
                mem_write_en = 1'b1;
                mem_address  = BASE_ADDR + ADDR_WIDTH'(word_index);
                mem_data     = current_word;
                busy         = 1'b1;
                if (mem_ready) begin
                    if (word_index == LAST_INDEX) begin
                        state_next = DONE;
                    end else begin
                        index_next = word_index + 1'b1;
                    end
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hash_writer.sv
// Self-checking bench for hash_writer: table of transfers with stalls, plus
// hand-written reset, restart-attempt and round-trip sequences.
module tb_hash_writer;

    localparam int          HL   = 8;
    localparam int          AW   = 16;
    localparam logic [15:0] BASE = 16'h0040;
    localparam logic [255:0] SHA_INIT =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic [HL*32-1:0] hash_vector;
    logic           mem_ready;
    logic [AW-1:0]  mem_address;
    logic [31:0]    mem_data;
    logic           mem_write_en;
    logic           busy;
    logic           done;

    always #5 clock = ~clock;

    hash_writer #(
        .HASH_LENGTH(HL),
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .hash_vector (hash_vector),
        .mem_ready   (mem_ready),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_write_en(mem_write_en),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        logic [255:0] vec;
        bit           shift_pattern;
        bit           round_trip;
        int           stall_word;
        int           stall_len;
        int           exp_write_cycles;
        int           exp_done_cycle;
    } vector_t;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    vector_t     table_v[4];
    wr_t         exp_q[$];
    wr_t         mon_entry;
    int          mon_slot;
    logic [31:0] mem_model[HL];
    int          write_count[HL];

    int checks_total  = 0;
    int checks_passed = 0;
    int cycle         = 0;
    int write_cycles, done_count, done_cycle, writes_done;
    int busy_errors, hold_errors, unexpected_writes;
    logic            hold_pending = 1'b0;
    logic [AW-1:0]   hold_addr;
    logic [31:0]     hold_data;
    logic [255:0]    shift_vec;

    task automatic check_output(input string name, input logic [255:0] actual,
                                input logic [255:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    function automatic logic [31:0] expected_word(input logic [255:0] v, input int k);
        logic [31:0] w;
        for (int b = 0; b < 32; b++) w[31-b] = v[k*32+b];
        return w;
    endfunction

    // Assembler read mapping: vector[k*32+b] = mem[k][31-b].
    function automatic logic [255:0] reassemble();
        logic [255:0] v;
        for (int k = 0; k < HL; k++)
            for (int b = 0; b < 32; b++) v[k*32+b] = mem_model[k][31-b];
        return v;
    endfunction

    always @(negedge clock) begin
        if (mem_write_en) write_cycles++;
        if (mem_write_en && !busy) busy_errors++;
        if (done) begin
            done_count++;
            done_cycle = cycle;
            if (!busy || mem_write_en) busy_errors++;
        end
        if (hold_pending && mem_write_en &&
            (mem_address !== hold_addr || mem_data !== hold_data)) hold_errors++;
        hold_pending = mem_write_en && !mem_ready;
        hold_addr    = mem_address;
        hold_data    = mem_data;
        if (mem_write_en && mem_ready) begin
            writes_done++;
            if (exp_q.size() == 0) begin
                unexpected_writes++;
            end else begin
                mon_entry = exp_q.pop_front();
                check_output("write_addr", 256'(mem_address), 256'(mon_entry.addr));
                check_output("write_data", 256'(mem_data), 256'(mon_entry.data));
            end
            mon_slot = int'(mem_address - BASE);
            if (mon_slot >= 0 && mon_slot < HL) begin
                write_count[mon_slot]++;
                mem_model[mon_slot] = mem_data;
            end else begin
                unexpected_writes++;
            end
        end
    end

    // Pushes the expected writes, then presents start for exactly one edge.
    task automatic apply_stimulus(input logic [255:0] vec, input bit shift_pattern);
        wr_t e;
        write_cycles = 0; done_count = 0; done_cycle = -1; writes_done = 0;
        busy_errors = 0; hold_errors = 0; unexpected_writes = 0;
        for (int k = 0; k < HL; k++) begin
            write_count[k] = 0;
            mem_model[k]   = '0;
            e.addr = BASE + 16'(k);
            e.data = shift_pattern ? (32'h8000_0000 >> k) : expected_word(vec, k);
            exp_q.push_back(e);
        end
        cycle       = 0;
        hash_vector = vec;
        mem_ready   = 1'b1;
        start       = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic run_transfer(input int stall_word, input int stall_len,
                                input int exp_wc, input int exp_done, input int poke);
        int c = 1;
        while (done_count == 0 && c < 40) begin
            cycle     = c;
            mem_ready = !(c >= stall_word + 1 && c <= stall_word + stall_len);
            if (poke != 0 && c == poke) begin
                start       = 1'b1;
                hash_vector = ~hash_vector;
            end
            if (poke != 0 && c == poke + 1) start = 1'b0;
            @(posedge clock); #1;
            c++;
        end
        start     = 1'b0;
        cycle     = c;
        mem_ready = 1'b1;
        @(negedge clock); #1;
        check_output("idle_write_en", 256'(mem_write_en), 256'(0));
        check_output("idle_busy", 256'(busy), 256'(0));
        check_output("idle_done", 256'(done), 256'(0));
        check_output("done_cycle", 256'(done_cycle), 256'(exp_done));
        check_output("done_pulses", 256'(done_count), 256'(1));
        check_output("write_cycles", 256'(write_cycles), 256'(exp_wc));
        check_output("pending_writes", 256'(exp_q.size()), 256'(0));
        check_output("unexpected_writes", 256'(unexpected_writes), 256'(0));
        check_output("busy_errors", 256'(busy_errors), 256'(0));
        check_output("stall_hold_errors", 256'(hold_errors), 256'(0));
        for (int k = 0; k < HL; k++)
            check_output($sformatf("writes_at_%0d", k), 256'(write_count[k]), 256'(1));
        @(posedge clock); #1;
    endtask

    initial begin
        for (int k = 0; k < HL; k++) shift_vec[k*32 +: 32] = 32'h0000_0001 << k;

        table_v[0] = '{shift_vec, 1'b1, 1'b0, 99, 0, 8, 9};
        table_v[1] = '{shift_vec, 1'b1, 1'b0, 2, 3, 11, 12};
        table_v[2] = '{SHA_INIT, 1'b0, 1'b1, 99, 0, 8, 9};
        table_v[3] = '{256'hdeadbeef_01234567_89abcdef_cafef00d_a5a5a5a5_0f0f0f0f_80000001_fffe0001,
                       1'b0, 1'b0, 7, 2, 10, 11};

        // Reset held low while start is requested: nothing may happen.
        reset       = 1'b0;
        start       = 1'b1;
        hash_vector = '1;
        mem_ready   = 1'b1;
        writes_done = 0; unexpected_writes = 0; write_cycles = 0;
        done_count = 0; busy_errors = 0; hold_errors = 0; done_cycle = -1;
        repeat (3) @(posedge clock);
        @(negedge clock); #1;
        check_output("rst_write_en", 256'(mem_write_en), 256'(0));
        check_output("rst_busy", 256'(busy), 256'(0));
        check_output("rst_done", 256'(done), 256'(0));
        check_output("rst_address", 256'(mem_address), 256'(0));
        check_output("rst_data", 256'(mem_data), 256'(0));
        check_output("rst_no_writes", 256'(writes_done), 256'(0));
        start = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;

        for (int i = 0; i < 4; i++) begin
            $display("[TB] table entry %0d", i);
            apply_stimulus(table_v[i].vec, table_v[i].shift_pattern);
            run_transfer(table_v[i].stall_word, table_v[i].stall_len,
                         table_v[i].exp_write_cycles, table_v[i].exp_done_cycle, 0);
            if (table_v[i].round_trip)
                check_output("round_trip", reassemble(), SHA_INIT);
        end

        $display("[TB] restart attempt during WRITE");
        apply_stimulus(SHA_INIT, 1'b0);
        run_transfer(99, 0, 8, 9, 3);
        check_output("restart_round_trip", reassemble(), SHA_INIT);

        $display("[TB] reset mid-transfer");
        apply_stimulus(shift_vec, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            cycle     = c;
            mem_ready = 1'b1;
            @(posedge clock); #1;
        end
        reset = 1'b0;
        exp_q.delete();
        cycle = 6;
        @(negedge clock); #1;
        check_output("abort_write_en", 256'(mem_write_en), 256'(0));
        check_output("abort_busy", 256'(busy), 256'(0));
        check_output("abort_address", 256'(mem_address), 256'(0));
        check_output("abort_data", 256'(mem_data), 256'(0));
        check_output("abort_writes_done", 256'(writes_done), 256'(5));
        check_output("abort_unexpected", 256'(unexpected_writes), 256'(0));
        @(posedge clock); #1;
        check_output("abort_stays_idle", 256'(busy), 256'(0));
        reset = 1'b1;
        apply_stimulus(shift_vec, 1'b1);
        run_transfer(99, 0, 8, 9, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
